// File: rtl/enc_pkg.sv
// Shared types for the pipelined binary-to-one-hot/thermometer encoder.
//   enc_mode_e  : per-item encoding selector
//   buf_state_e : occupancy of the 2-entry output buffer
package enc_pkg;

    typedef enum logic {
        ENC_ONEHOT = 1'b0,
        ENC_THERM  = 1'b1
    } enc_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/enc_bin2onehot_pipe_if.sv
// Handshake bundle for enc_bin2onehot_pipe.
//   input side : in_valid/in_ready, in, in_mode
//   output side: out_valid/out_ready, out, out_err
//   error count: err_cnt, err_clr
// master = upstream/downstream environment, slave = the encoder block.
interface enc_bin2onehot_pipe_if #(
    parameter int unsigned IN_W      = 4,
    parameter int unsigned OUT_W     = 15,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 err_clr;

    modport master (
        output in_valid, in, in_mode, out_ready, err_clr,
        input  in_ready, out_valid, out, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in, in_mode, out_ready, err_clr,
        output in_ready, out_valid, out, out_err, err_cnt
    );
endinterface

// File: rtl/enc_bin2onehot_core.sv
// Combinational encoder: binary index -> one-hot or thermometer code.
//   in   : binary index
//   mode : ENC_ONEHOT or ENC_THERM
//   code : encoded value (all 0 one-hot / all 1 thermometer when out of range)
//   err  : index >= OUT_W
module enc_bin2onehot_core
    import enc_pkg::*;
#(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 15
) (
    input  logic [IN_W-1:0]  in,
    input  enc_mode_e        mode,
    output logic [OUT_W-1:0] code,
    output logic             err
);

    // Out-of-range handling falls out of the compares: no k equals in, every k is below it.
    always_comb begin
        code = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            if (mode == ENC_THERM) begin
                code[k] = (k <= 32'(in));
            end else begin
                code[k] = (k == 32'(in));
            end
        end
        err = (32'(in) >= OUT_W);
    end

endmodule

// File: rtl/enc_bin2onehot_pipe.sv
// Flow-controlled binary encoder with a 2-entry output buffer and a
// saturating out-of-range counter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : enc_bin2onehot_pipe_if.slave (input handshake, output handshake,
//         err_cnt / err_clr)
module enc_bin2onehot_pipe
    import enc_pkg::*;
#(
    parameter int unsigned IN_W      = 4,
    parameter int unsigned OUT_W     = 15,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    enc_bin2onehot_pipe_if.slave  bus
);

    localparam int unsigned ENT_W = OUT_W + 1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [OUT_W-1:0]     enc_code;
    logic                 enc_err;

    buf_state_e           state_q, state_d;
    logic                 head_q, head_d;
    logic [ENT_W-1:0]     buf_q [2];
    logic [ENT_W-1:0]     buf_d [2];
    logic [ENT_W-1:0]     head_ent_d;
    logic                 wr_idx;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [OUT_W-1:0]     out_q;
    logic                 out_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 push;
    logic                 pop;

    // Encode at the input so the buffer stores finished results.
    enc_bin2onehot_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in   (bus.in),
        .mode (enc_mode_e'(bus.in_mode)),
        .code (enc_code),
        .err  (enc_err)
    );

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    // Next buffer state, write slot, head pointer and next head entry.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        buf_d      = buf_q;
        wr_idx     = (state_q == EMPTY) ? head_q : ~head_q;
        head_ent_d = '0;

        if (push) begin
            buf_d[wr_idx] = {enc_err, enc_code};
        end
        if (pop) begin
            head_d = ~head_q;
        end

        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase

        if (state_d != EMPTY) begin
            head_ent_d = buf_d[head_d];
        end
    end

    // Buffer, state and registered handshake/outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            head_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            buf_q       <= buf_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            out_q       <= head_ent_d[OUT_W-1:0];
            out_err_q   <= head_ent_d[OUT_W];
        end
    end

    // Saturating count of accepted out-of-range items; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (bus.err_clr) begin
            err_cnt_q <= '0;
        end else if (push && enc_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Self-checking bench for enc_bin2onehot_pipe: table of encode vectors plus
// directed back-pressure, error-counter, saturation and async-reset sequences.
module tb_enc_bin2onehot_pipe;

    logic clk;
    logic rst;

    enc_bin2onehot_pipe_if #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(8)) bus ();
    enc_bin2onehot_pipe_if #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(2)) bus2 ();

    enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in;
        logic        mode;
        logic [14:0] exp_out;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{4'd0,  1'b0, 15'h0001, 1'b0};
        vecs[1] = '{4'd3,  1'b0, 15'h0008, 1'b0};
        vecs[2] = '{4'd14, 1'b0, 15'h4000, 1'b0};
        vecs[3] = '{4'd15, 1'b0, 15'h0000, 1'b1};
        vecs[4] = '{4'd0,  1'b1, 15'h0001, 1'b0};
        vecs[5] = '{4'd4,  1'b1, 15'h001F, 1'b0};
        vecs[6] = '{4'd14, 1'b1, 15'h7FFF, 1'b0};
        vecs[7] = '{4'd15, 1'b1, 15'h7FFF, 1'b1};
        vecs[8] = '{4'd7,  1'b1, 15'h00FF, 1'b0};
        vecs[9] = '{4'd9,  1'b0, 15'h0200, 1'b0};

        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in        = '0;
        bus2.in_mode   = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.err_clr   = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out",       32'(bus.out),       32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        check("rst2_out_valid", 32'(bus2.out_valid), 32'd0);

        // Table vectors, streamed back-to-back with out_ready high
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = vecs[i].in;
            bus.in_mode  = vecs[i].mode;
            @(negedge clk);
            check($sformatf("vec%0d_out", i),       32'(bus.out),       32'(vecs[i].exp_out));
            check($sformatf("vec%0d_out_err", i),   32'(bus.out_err),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'd1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("drain_out",       32'(bus.out),       32'd0);
        check("table_err_cnt",   32'(bus.err_cnt),   32'd2);

        // Back-pressure: fill to FULL, extra item ignored, FIFO order on release
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'd1;
        bus.in_mode   = 1'b0;
        @(negedge clk);
        check("bp1_out",      32'(bus.out),      32'h0002);
        check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in = 4'd5;
        @(negedge clk);
        check("bp2_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp2_out",       32'(bus.out),       32'h0002);
        check("bp2_out_valid", 32'(bus.out_valid), 32'd1);
        bus.in = 4'd9;
        @(negedge clk);
        check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp3_out_hold", 32'(bus.out),      32'h0002);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp4_out",       32'(bus.out),       32'h0020);
        check("bp4_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp4_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        check("bp5_out_valid", 32'(bus.out_valid), 32'd0);

        // Error counter: clear, three errors, clear beats a coincident fourth
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.in       = 4'd15;
            bus.in_mode  = 1'b0;
            @(negedge clk);
            check($sformatf("err%0d_out", j),     32'(bus.out),     32'd0);
            check($sformatf("err%0d_out_err", j), 32'(bus.out_err), 32'd1);
            check($sformatf("err%0d_cnt", j),     32'(bus.err_cnt), 32'(j + 1));
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        check("err_clr_win_cnt", 32'(bus.err_cnt), 32'd0);
        check("err_clr_out_err", 32'(bus.out_err), 32'd1);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        @(negedge clk);
        check("err_end_valid", 32'(bus.out_valid), 32'd0);
        check("err_end_cnt",   32'(bus.err_cnt),   32'd0);

        // Saturation on the 2-bit counter instance
        bus2.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus2.in_valid = 1'b1;
            bus2.in       = 4'd15;
            bus2.in_mode  = 1'b1;
            @(negedge clk);
            check($sformatf("sat%0d_cnt", j), 32'(bus2.err_cnt), (j < 3) ? 32'(j + 1) : 32'd3);
        end
        bus2.in_valid = 1'b0;
        check("sat_out", 32'(bus2.out), 32'h7FFF);

        // Async reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 4'd15;
        bus.in_mode   = 1'b1;
        @(negedge clk);
        bus.in      = 4'd2;
        bus.in_mode = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("pre_rst_err_cnt",  32'(bus.err_cnt),  32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_err_cnt",   32'(bus.err_cnt),   32'd0);
        check("arst_out",       32'(bus.out),       32'd0);
        check("arst_out_err",   32'(bus.out_err),   32'd0);
        check("arst2_err_cnt",  32'(bus2.err_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in       = 4'd6;
        bus.in_mode  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("post_rst_out",       32'(bus.out),       32'h0040);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
